// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, defaults and helpers for the data-memory responder
package dmem_pkg;

    localparam int DMEM_DEPTH_DEFAULT   = 32;
    localparam int DMEM_LATENCY_DEFAULT = 3;
    localparam int CNT_W                = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // A byte address is illegal when it is not word aligned or lies past the last word.
    function automatic logic addr_error(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (addr >= 32'(4 * depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage, sync write / async read, byte strobes under DMEM_BYTE_STROBE_EN
module dmem_array #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]    be,
`endif
    output logic [31:0]   rdata
);

    // Contents are deliberately left unreset so the array maps onto plain RAM.
    logic [31:0] mem [DEPTH];

`ifdef DMEM_BYTE_STROBE_EN
    // Update only the lanes whose strobe is set; an all-zero strobe writes nothing.
    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end
`else
    // Full-word write.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end
`endif

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder (byte strobes with DMEM_BYTE_STROBE_EN)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DMEM_DEPTH_DEFAULT,
    parameter int LATENCY = DMEM_LATENCY_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  be_i,
`endif
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int AW = $clog2(DEPTH);

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]       be_q;
`endif
    logic [31:0]      rdata_q;

    logic             accept;
    logic             enter_resp;
    logic             sel_we;
    logic [31:0]      sel_addr;
    logic             mem_we;
    logic [31:0]      mem_rdata;

    assign accept = (state_q == ST_IDLE) && req_i;

    // With LATENCY=1 the response is entered straight from IDLE, before the
    // request registers hold the new fields, so reads look at the live inputs then.
    assign sel_we   = accept ? we_i   : we_q;
    assign sel_addr = accept ? addr_i : addr_q;

    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign mem_we     = (state_q == ST_RESP) && we_q && !addr_error(addr_q, DEPTH);

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i (clk_i),
        .we    (mem_we),
        .addr  (sel_addr[2 +: AW]),
        .wdata (wdata_q),
`ifdef DMEM_BYTE_STROBE_EN
        .be    (be_q),
`endif
        .rdata (mem_rdata)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, count down in WAIT, one RESP cycle then back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch the request on acceptance and run the latency down-counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef DMEM_BYTE_STROBE_EN
            be_q    <= '0;
`endif
        end else if (accept) begin
            cnt_q   <= CNT_W'(LATENCY - 1);
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
`ifdef DMEM_BYTE_STROBE_EN
            be_q    <= be_i;
`endif
        end else if (state_q == ST_WAIT) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Capture read data on entry to RESP; writes and errors return zero, value holds otherwise.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else if (enter_resp) begin
            rdata_q <= (sel_we || addr_error(sel_addr, DEPTH)) ? '0 : mem_rdata;
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        ack_o   = (state_q == ST_RESP);
        err_o   = (state_q == ST_RESP) && addr_error(addr_q, DEPTH);
        stall_o = req_i && (state_q != ST_RESP);
        rdata_o = rdata_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (LATENCY 3 and 1 instances)
module tb_dmem_responder;

    localparam int LAT0  = 3;
    localparam int WORDS = 32;
`ifdef DMEM_BYTE_STROBE_EN
    localparam bit HAS_BE = 1'b1;
`else
    localparam bit HAS_BE = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req, we_r;
    logic [31:0] addr_r, wdata_r;
    logic [3:0]  be_r;
    logic        ack_o, err_o, stall_o;
    logic [31:0] rdata_o;
    logic        req1, we1;
    logic [31:0] addr1, wdata1;
    logic [3:0]  be1;
    logic        ack1, err1, stall1;
    logic [31:0] rdata1;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rd;
    logic [31:0] mem_m [WORDS];
    vec_t        vecs [13];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(WORDS), .LATENCY(LAT0)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .req_i   (req),
        .we_i    (we_r),
        .addr_i  (addr_r),
        .wdata_i (wdata_r),
`ifdef DMEM_BYTE_STROBE_EN
        .be_i    (be_r),
`endif
        .ack_o   (ack_o),
        .rdata_o (rdata_o),
        .err_o   (err_o),
        .stall_o (stall_o)
    );

    dmem_responder #(.DEPTH(WORDS), .LATENCY(1)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .req_i   (req1),
        .we_i    (we1),
        .addr_i  (addr1),
        .wdata_i (wdata1),
`ifdef DMEM_BYTE_STROBE_EN
        .be_i    (be1),
`endif
        .ack_o   (ack1),
        .rdata_o (rdata1),
        .err_o   (err1),
        .stall_o (stall1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour: legality, read value and storage update from the address rules.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic err, output logic [31:0] rd);
        logic [3:0] eb;
        eb  = HAS_BE ? be : 4'hF;
        err = (addr % 4 != 0) || (addr >= 4 * WORDS);
        rd  = 32'h0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (eb[b]) mem_m[addr / 4][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rd = mem_m[addr / 4];
            end
        end
    endtask

    // One transaction on the LATENCY=3 instance; fields are scrambled after acceptance.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input bit drop,
                          output logic err, output logic [31:0] rdata);
        int lat;
        bit held;
        @(negedge clk);
        chk("ack_idle", ack_o, 0);
        chk("rdata_hold", rdata_o, last_rd);
        req = 1'b1; we_r = we; addr_r = addr; wdata_r = wdata; be_r = be;
        #1;
        chk("stall_accept", stall_o, 1);
        @(posedge clk);
        #1;
        we_r = 1'($urandom); addr_r = $urandom; wdata_r = $urandom; be_r = 4'($urandom);
        held = !drop;
        if (drop) req = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!ack_o && lat < 20) begin
            chk("stall_wait", stall_o, held);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, LAT0);
        chk("stall_ack", stall_o, 0);
        err     = err_o;
        rdata   = rdata_o;
        last_rd = rdata_o;
        req     = 1'b0;
    endtask

    task automatic run_checked(input string name, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be, input bit drop);
        logic        e_err, a_err;
        logic [31:0] e_rd, a_rd;
        model(we, addr, wdata, be, e_err, e_rd);
        do_txn(we, addr, wdata, be, drop, a_err, a_rd);
        chk({name, "_err"}, a_err, e_err);
        chk({name, "_rdata"}, a_rd, e_rd);
    endtask

    initial begin
        logic        a_err;
        logic [31:0] a_rd, addr;
        rst_i = 1'b0; req = 0; we_r = 0; addr_r = 0; wdata_r = 0; be_r = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; be1 = 0; last_rd = 0;

        vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 32'h13,       32'h0,        4'hF, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 32'h80,       32'h0,        4'hF, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 32'h80,       32'h11111111, 4'hF, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 32'h12,       32'h22222222, 4'hF, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 32'hDEADBEEF};
        vecs[7]  = '{1'b0, 32'h7C,       32'h0,        4'hF, 1'b0, 32'hC0DE001F};
        vecs[8]  = '{1'b1, 32'h7C,       32'h0BADF00D, 4'hF, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h7C,       32'h0,        4'hF, 1'b0, 32'h0BADF00D};
        vecs[10] = '{1'b0, 32'h00,       32'h0,        4'hF, 1'b0, 32'hC0DE0000};
        vecs[11] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'hF, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 32'h100,      32'h0,        4'hF, 1'b1, 32'h0};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_ack", ack_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_rdata1", rdata1, 0);
        rst_i = 1'b1;

        // Fill storage with known contents.
        for (int i = 0; i < WORDS; i++)
            run_checked("init", 1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(i), 4'hF, 1'b0);

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            logic        m_err;
            logic [31:0] m_rd;
            model(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, m_err, m_rd);
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b0, a_err, a_rd);
            chk($sformatf("vec%0d_err", i), a_err, vecs[i].exp_err);
            chk($sformatf("vec%0d_rdata", i), a_rd, vecs[i].exp_rdata);
        end

`ifdef DMEM_BYTE_STROBE_EN
        run_checked("be_full", 1'b1, 32'h0, 32'hAABBCCDD, 4'hF, 1'b0);
        run_checked("be_0101", 1'b1, 32'h0, 32'h11223344, 4'b0101, 1'b0);
        do_txn(1'b0, 32'h0, 32'h0, 4'hF, 1'b0, a_err, a_rd);
        chk("be_merge", a_rd, 32'hAA22CC44);
        run_checked("be_none", 1'b1, 32'h0, 32'hFFFFFFFF, 4'b0000, 1'b0);
        run_checked("be_after_none", 1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
`endif

        // Reset in the middle of a write aborts it.
        run_checked("pre_rst_rd", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        req = 1'b1; we_r = 1'b1; addr_r = 32'h04; wdata_r = 32'h12345678; be_r = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0; req = 1'b0;
        #1;
        chk("midrst_ack", ack_o, 0);
        chk("midrst_err", err_o, 0);
        chk("midrst_rdata", rdata_o, 0);
        chk("midrst_stall", stall_o, 0);
        @(negedge clk);
        rst_i = 1'b1;
        last_rd = 32'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("midrst_no_ack", ack_o, 0);
        end
        run_checked("post_rst_rd", 1'b0, 32'h04, 32'h0, 4'hF, 1'b0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 80; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      addr = {25'h0, 5'($urandom), 2'($urandom_range(1, 3))};
            else if (sel == 1) addr = $urandom | 32'h80;
            else               addr = {25'h0, 5'($urandom), 2'b00};
            run_checked("rand", 1'($urandom), addr, $urandom, 4'($urandom), bit'($urandom_range(0, 3) == 0));
        end

        // LATENCY=1: held request acks every second cycle.
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h08; wdata1 = 32'h5A5AA5A5; be1 = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("l1_pattern%0d", k), ack1, k % 2);
        end
        @(posedge clk);
        #1;
        req1 = 1'b0; we1 = 1'b0;
        @(negedge clk);
        chk("l1_drop_ack", ack1, 1);
        chk("l1_drop_err", err1, 0);
        @(negedge clk);
        chk("l1_single_pulse", ack1, 0);
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h08;
        @(negedge clk);
        chk("l1_rd_ack", ack1, 1);
        chk("l1_rd_data", rdata1, 32'h5A5AA5A5);
        req1 = 1'b0;
        @(negedge clk);
        req1 = 1'b1; addr1 = 32'h81;
        @(negedge clk);
        chk("l1_err_ack", ack1, 1);
        chk("l1_err", err1, 1);
        chk("l1_err_rdata", rdata1, 0);
        req1 = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
